// File: rtl/cdm16_mem_responder.sv
// cdm16_mem_responder: byte-addressed little-endian RAM serving the cdm16 memory bus.
// Optional wait states are compiled in when CDM16_RESP_WAIT_EN is defined.
module cdm16_mem_responder #(
  parameter int ADDR_BITS   = 12,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem,
  input  logic        data,
  input  logic        read,
  input  logic        word,
  input  logic [15:0] address,
  input  logic [15:0] wdata,
  output logic [15:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        fault,
  output logic [15:0] fault_addr,
  input  logic        fault_clr
);

  localparam int IW = ADDR_BITS - 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RESP = 2'd2
`ifdef CDM16_RESP_WAIT_EN
    , S_WAIT = 2'd1
`endif
  } state_t;

  state_t r_state;

  // Two byte lanes of word-indexed storage: lo holds even addresses, hi holds odd.
  logic [7:0] r_mem_lo [0:(1<<IW)-1];
  logic [7:0] r_mem_hi [0:(1<<IW)-1];

  logic          w_read, w_word, w_data;
  logic [15:0]   w_addr, w_wdata;
  logic [IW-1:0] w_idx;
  logic          w_illegal;
  logic          w_enter_resp;
  logic [15:0]   w_rdata_mem;

`ifdef CDM16_RESP_WAIT_EN
  localparam bit WAIT_ON = (WAIT_CYCLES > 0);
  logic        r_read, r_word, r_data;
  logic [15:0] r_addr, r_wdata;
  logic [3:0]  r_wait_cnt;
`else
  logic [3:0] w_unused_wait;
  assign w_unused_wait = 4'(WAIT_CYCLES);
`endif

  // In IDLE the access may complete on the accept edge itself, so the live bus
  // fields are used there; once waiting, the latched copies are used.
  always_comb begin
    w_read  = read;
    w_word  = word;
    w_data  = data;
    w_addr  = address;
    w_wdata = wdata;
`ifdef CDM16_RESP_WAIT_EN
    if (r_state != S_IDLE) begin
      w_read  = r_read;
      w_word  = r_word;
      w_data  = r_data;
      w_addr  = r_addr;
      w_wdata = r_wdata;
    end
`endif
  end

  assign w_idx     = w_addr[ADDR_BITS-1:1];
  assign w_illegal = ((w_addr >> ADDR_BITS) != 16'd0) | (w_word & w_addr[0]) | (~w_read & ~w_data);
  assign w_rdata_mem = w_word ? {r_mem_hi[w_idx], r_mem_lo[w_idx]}
                              : {8'h00, (w_addr[0] ? r_mem_hi[w_idx] : r_mem_lo[w_idx])};

`ifdef CDM16_RESP_WAIT_EN
  assign w_enter_resp = ((r_state == S_IDLE) && mem && !WAIT_ON) ||
                        ((r_state == S_WAIT) && (r_wait_cnt == 4'd0));
`else
  assign w_enter_resp = (r_state == S_IDLE) && mem;
`endif

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // in this block sees pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      ready      <= 1'b0;
      busy       <= 1'b0;
      rdata      <= 16'h0000;
      fault      <= 1'b0;
      fault_addr <= 16'h0000;
`ifdef CDM16_RESP_WAIT_EN
      r_wait_cnt <= 4'd0;
      r_read     <= 1'b0;
      r_word     <= 1'b0;
      r_data     <= 1'b0;
      r_addr     <= 16'h0000;
      r_wdata    <= 16'h0000;
`endif
    end else begin
      ready <= 1'b0;
      busy  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (mem) begin
`ifdef CDM16_RESP_WAIT_EN
            r_read  <= read;
            r_word  <= word;
            r_data  <= data;
            r_addr  <= address;
            r_wdata <= wdata;
            if (WAIT_ON) begin
              r_wait_cnt <= 4'(WAIT_CYCLES - 1);
              busy       <= 1'b1;
              r_state    <= S_WAIT;
            end else begin
              ready   <= 1'b1;
              r_state <= S_RESP;
            end
`else
            ready   <= 1'b1;
            r_state <= S_RESP;
`endif
          end
        end
`ifdef CDM16_RESP_WAIT_EN
        S_WAIT: begin
          if (r_wait_cnt == 4'd0) begin
            ready   <= 1'b1;
            r_state <= S_RESP;
          end else begin
            r_wait_cnt <= r_wait_cnt - 4'd1;
            busy       <= 1'b1;
          end
        end
`endif
        S_RESP:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase

      if (w_enter_resp) begin
        if (w_illegal)   rdata <= 16'h0000;
        else if (w_read) rdata <= w_rdata_mem;
      end

      // A fault on the same edge as a clear wins over the clear.
      if (w_enter_resp && w_illegal) begin
        fault <= 1'b1;
        if (!fault || fault_clr) fault_addr <= w_addr;
      end else if (fault_clr) begin
        fault      <= 1'b0;
        fault_addr <= 16'h0000;
      end
    end
  end

  // NOTE: the RAM array has no reset; contents survive reset, only the write
  // strobe is gated so an in-flight write is dropped.
  always_ff @(posedge clk) begin
    if (!reset && w_enter_resp && !w_illegal && !w_read) begin
      if (w_word) begin
        r_mem_lo[w_idx] <= w_wdata[7:0];
        r_mem_hi[w_idx] <= w_wdata[15:8];
      end else if (w_addr[0]) begin
        r_mem_hi[w_idx] <= w_wdata[7:0];
      end else begin
        r_mem_lo[w_idx] <= w_wdata[7:0];
      end
    end
  end

endmodule

// File: tb/tb_cdm16_mem_responder.sv
// Scoreboard bench for cdm16_mem_responder: expected responses are queued at
// issue time and compared when ready pulses; timing of busy/ready checked per access.
module tb_cdm16_mem_responder;

`ifdef CDM16_RESP_WAIT_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        reset, mem, data, read, word, fault_clr;
  logic [15:0] address, wdata;
  logic [15:0] rdata, fault_addr;
  logic        ready, busy, fault;

  cdm16_mem_responder #(.ADDR_BITS(12), .WAIT_CYCLES(3)) dut (
    .clk(clk), .reset(reset), .mem(mem), .data(data), .read(read), .word(word),
    .address(address), .wdata(wdata), .rdata(rdata), .ready(ready), .busy(busy),
    .fault(fault), .fault_addr(fault_addr), .fault_clr(fault_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    bit          chk_rdata;
    logic [15:0] rdata;
    logic        fault;
    logic [15:0] faddr;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [7:0]  mdl [0:4095];
  logic [15:0] m_rdata = 16'h0000;
  bit          m_known = 1'b1;
  logic        m_fault = 1'b0;
  logic [15:0] m_faddr = 16'h0000;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (ready) begin
      if (sb.size() == 0) begin
        check("unexpected_ready", 32'(ready), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (e.chk_rdata) check({e.tag, ".rdata"}, 32'(rdata), 32'(e.rdata));
        check({e.tag, ".fault"}, 32'(fault), 32'(e.fault));
        check({e.tag, ".fault_addr"}, 32'(fault_addr), 32'(e.faddr));
      end
    end
  end

  task automatic access(input string tag, input logic a_data, input logic a_read,
                        input logic a_word, input logic [15:0] a_addr,
                        input logic [15:0] a_wdata, input bit a_clr);
    exp_t e;
    logic ill;
    ill = (a_addr[15:12] != 4'h0) || (a_word && a_addr[0]) || (!a_read && !a_data);
    if (ill) begin
      if (!m_fault || a_clr) m_faddr = a_addr;
      m_fault = 1'b1;
    end else if (a_clr) begin
      m_fault = 1'b0;
      m_faddr = 16'h0000;
    end
    if (!ill && !a_read) begin
      mdl[a_addr[11:0]] = a_wdata[7:0];
      if (a_word) mdl[a_addr[11:0] + 12'd1] = a_wdata[15:8];
    end
    e.tag = tag;
    if (a_read) begin
      if (ill)         m_rdata = 16'h0000;
      else if (a_word) m_rdata = {mdl[a_addr[11:0] + 12'd1], mdl[a_addr[11:0]]};
      else             m_rdata = {8'h00, mdl[a_addr[11:0]]};
      m_known = 1'b1;
      e.chk_rdata = 1'b1;
    end else if (ill) begin
      m_known = 1'b0;
      e.chk_rdata = 1'b0;
    end else begin
      e.chk_rdata = m_known;
    end
    e.rdata = m_rdata;
    e.fault = m_fault;
    e.faddr = m_faddr;
    sb.push_back(e);

    @(negedge clk);
    mem = 1'b1; data = a_data; read = a_read; word = a_word;
    address = a_addr; wdata = a_wdata;
    fault_clr = a_clr && (LAT == 1);
    @(posedge clk);
    #1 mem = 1'b0;
    if (LAT == 1) fault_clr = 1'b0;
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      check($sformatf("%s.busy%0d", tag, k), 32'(busy), 32'(k < LAT));
      check($sformatf("%s.ready%0d", tag, k), 32'(ready), 32'(k == LAT));
      if (a_clr && k == LAT - 1) fault_clr = 1'b1;
      if (k == LAT) fault_clr = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b1; mem = 1'b0; data = 1'b0; read = 1'b0; word = 1'b0;
    address = 16'h0000; wdata = 16'h0000; fault_clr = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.ready", 32'(ready), 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.rdata", 32'(rdata), 32'd0);
    check("rst.fault", 32'(fault), 32'd0);
    check("rst.fault_addr", 32'(fault_addr), 32'd0);
    reset = 1'b0;

    // Word write/read, byte read of the high half, byte merge.
    access("wr_beef", 1, 0, 1, 16'h0010, 16'hBEEF, 0);
    access("rd_beef", 1, 1, 1, 16'h0010, 16'h0000, 0);
    access("rdb_11",  1, 1, 0, 16'h0011, 16'h0000, 0);
    access("wrb_5a",  1, 0, 0, 16'h0011, 16'h005A, 0);
    access("rd_5aef", 1, 1, 1, 16'h0010, 16'h0000, 0);

    // Faults: misaligned read, out-of-range write, instruction-space write.
    access("wr_0000", 1, 0, 1, 16'h0000, 16'h7788, 0);
    access("wr_0020", 1, 0, 1, 16'h0020, 16'hC3D2, 0);
    access("rd_mis3", 1, 1, 1, 16'h0003, 16'h0000, 0);
    access("wr_f000", 1, 0, 1, 16'hF000, 16'h1111, 0);
    access("rd_0000", 1, 1, 1, 16'h0000, 16'h0000, 0);
    access("wr_inst", 0, 0, 1, 16'h0020, 16'h9999, 0);
    access("rd_0020", 1, 1, 1, 16'h0020, 16'h0000, 0);
    access("clr_2000", 1, 1, 1, 16'h2000, 16'h0000, 1);

    // Reset while a write is in flight: nothing committed, outputs cleared.
    access("wr_0040", 1, 0, 1, 16'h0040, 16'hAAAA, 0);
`ifdef CDM16_RESP_WAIT_EN
    @(negedge clk);
    mem = 1'b1; data = 1'b1; read = 1'b0; word = 1'b1;
    address = 16'h0040; wdata = 16'h1234;
    @(posedge clk);
    #1 mem = 1'b0;
    @(negedge clk);
    check("rstmid.busy_wait", 32'(busy), 32'd1);
    reset = 1'b1;
`else
    @(negedge clk);
    mem = 1'b1; data = 1'b1; read = 1'b0; word = 1'b1;
    address = 16'h0040; wdata = 16'h1234;
    reset = 1'b1;
    @(posedge clk);
    #1 mem = 1'b0;
`endif
    @(negedge clk);
    check("rstmid.busy", 32'(busy), 32'd0);
    check("rstmid.ready", 32'(ready), 32'd0);
    check("rstmid.fault", 32'(fault), 32'd0);
    check("rstmid.fault_addr", 32'(fault_addr), 32'd0);
    reset = 1'b0;
    m_fault = 1'b0; m_faddr = 16'h0000; m_rdata = 16'h0000; m_known = 1'b1;
    @(negedge clk);
    check("rstmid.ready_after", 32'(ready), 32'd0);
    access("rd_0040", 1, 1, 1, 16'h0040, 16'h0000, 0);

    // Standalone clear after a fresh fault.
    access("rd_mis5", 1, 1, 1, 16'h0005, 16'h0000, 0);
    @(negedge clk);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    m_fault = 1'b0; m_faddr = 16'h0000;
    check("clr.fault", 32'(fault), 32'd0);
    check("clr.fault_addr", 32'(fault_addr), 32'd0);

    // Random word writes, byte overlays on the odd lane, word read-back.
    for (int i = 0; i < 8; i++) begin
      logic [15:0] a, w, b;
      a = 16'h0100 + 16'($urandom_range(0, 63) << 1);
      w = 16'($urandom);
      b = 16'($urandom);
      access($sformatf("rnd%0d.wr", i), 1, 0, 1, a, w, 0);
      access($sformatf("rnd%0d.wb", i), 1, 0, 0, a + 16'd1, b, 0);
      access($sformatf("rnd%0d.rd", i), 1, 1, 1, a, 16'h0000, 0);
      access($sformatf("rnd%0d.rb", i), 1, 1, 0, a, 16'h0000, 0);
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
